// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between a
// fetch requester (i_*) and a load/store requester (d_*).
//
// Data has fixed priority. A starvation guard forces fetch to win once
// STARVE_MAX consecutive data grants have been given while fetch was waiting.
// A watchdog aborts any transaction that sees no m_ready for TIMEOUT cycles.
// An aborted transaction returns zero data and sets the sticky err flag.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                fetch request and address
//   i_done/i_rdata              fetch completion pulse and read data
//   d_req/d_wr/d_addr/d_wdata   load/store request
//   d_done/d_rdata              data completion pulse and load data
//   m_en/m_wr/m_addr/m_wdata    memory start strobe and latched command
//   m_rdata/m_ready             memory read data and completion pulse
//   busy                        a transaction is in flight
//   err                         sticky timeout flag
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,   // legal range 1..15
  parameter int unsigned TIMEOUT    = 15   // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        m_en,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  starve_cnt_r;
  logic [7:0]  tmo_cnt_r;
  logic        err_r;
  logic        m_en_r;
  logic        m_wr_r;
  logic [15:0] m_addr_r;
  logic [15:0] m_wdata_r;

  logic        grant_i_s;
  logic        grant_d_s;
  logic        in_busy_s;
  logic        tmo_hit_s;
  logic        finish_s;
  logic        i_done_s;
  logic        d_done_s;

  // Arbitration and completion decode shared by next-state and register logic.
  always_comb begin
    grant_i_s = i_req && (!d_req || (starve_cnt_r == STARVE_LIM));
    grant_d_s = d_req && !grant_i_s;
    in_busy_s = (state_r == BUSY_I) || (state_r == BUSY_D);
    // m_ready on the last allowed cycle counts as a normal completion.
    tmo_hit_s = in_busy_s && !m_ready && (tmo_cnt_r == TMO_LAST);
    finish_s  = in_busy_s && (m_ready || tmo_hit_s);
    // A reset cycle swallows the done pulse of the abandoned transaction.
    i_done_s  = !rst && (state_r == BUSY_I) && finish_s;
    d_done_s  = !rst && (state_r == BUSY_D) && finish_s;
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_i_s) begin
          state_nxt_s = BUSY_I;
        end else if (grant_d_s) begin
          state_nxt_s = BUSY_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched memory command, starvation and timeout counters, err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      tmo_cnt_r    <= 8'd0;
      err_r        <= 1'b0;
      m_en_r       <= 1'b0;
      m_wr_r       <= 1'b0;
      m_addr_r     <= 16'h0000;
      m_wdata_r    <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      m_en_r  <= (state_r == IDLE) && (grant_i_s || grant_d_s);
      err_r   <= err_r | tmo_hit_s;
      if (state_r == IDLE) begin
        tmo_cnt_r <= 8'd0;
        if (grant_i_s) begin
          m_addr_r     <= i_addr;
          m_wr_r       <= 1'b0;
          m_wdata_r    <= 16'h0000;
          starve_cnt_r <= 4'd0;
        end else if (grant_d_s) begin
          m_addr_r  <= d_addr;
          m_wr_r    <= d_wr;
          m_wdata_r <= d_wdata;
          // Count only grants that made a waiting fetch lose.
          if (!i_req) begin
            starve_cnt_r <= 4'd0;
          end else if (starve_cnt_r != STARVE_LIM) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
          end else begin
            starve_cnt_r <= starve_cnt_r;
          end
        end else begin
          starve_cnt_r <= 4'd0;
        end
      end else if (!m_ready) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

  assign i_done  = i_done_s;
  assign d_done  = d_done_s;
  // A timed-out transaction returns zero data.
  assign i_rdata = (i_done_s && m_ready) ? m_rdata : 16'h0000;
  assign d_rdata = (d_done_s && m_ready) ? m_rdata : 16'h0000;
  assign m_en    = m_en_r;
  assign m_wr    = m_wr_r;
  assign m_addr  = m_addr_r;
  assign m_wdata = m_wdata_r;
  assign busy    = in_busy_s;
  assign err     = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (STARVE_MAX=4, TIMEOUT=15).
// Inputs are driven 1ns after the rising edge. Outputs are checked 1ns after that.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        m_en;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata = 16'h0000;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL reset_m_en got %b expected 0", m_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
    checks++; if ({m_wr, m_addr, m_wdata} !== 33'h0) begin errors++; $display("FAIL reset_mcmd got %h expected 0", {m_wr, m_addr, m_wdata}); end
    checks++; if ({i_done, d_done, i_rdata, d_rdata} !== 34'h0) begin errors++; $display("FAIL reset_done got %h expected 0", {i_done, d_done, i_rdata, d_rdata}); end
  endtask

  task automatic test_lone_fetch();
    step();
    i_req = 1'b1; i_addr = 16'h0040;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_c0_busy got %b expected 0", busy); end
    step(); // cycle 1
    #1;
    checks++; if (m_en !== 1'b1) begin errors++; $display("FAIL fetch_c1_m_en got %b expected 1", m_en); end
    checks++; if (m_addr !== 16'h0040) begin errors++; $display("FAIL fetch_c1_addr got %h expected 0040", m_addr); end
    checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL fetch_c1_wr got %b expected 0", m_wr); end
    checks++; if ({busy, i_done} !== 2'b10) begin errors++; $display("FAIL fetch_c1_busy_done got %b expected 10", {busy, i_done}); end
    step(); // cycle 2
    #1;
    checks++; if ({m_en, busy, i_done} !== 3'b010) begin errors++; $display("FAIL fetch_c2 got %b expected 010", {m_en, busy, i_done}); end
    step(); // cycle 3
    m_ready = 1'b1; m_rdata = 16'h1234;
    #1;
    checks++; if (i_done !== 1'b1) begin errors++; $display("FAIL fetch_c3_done got %b expected 1", i_done); end
    checks++; if (i_rdata !== 16'h1234) begin errors++; $display("FAIL fetch_c3_rdata got %h expected 1234", i_rdata); end
    checks++; if ({busy, d_done} !== 2'b10) begin errors++; $display("FAIL fetch_c3_busy_ddone got %b expected 10", {busy, d_done}); end
    step(); // cycle 4
    m_ready = 1'b0; i_req = 1'b0;
    #1;
    checks++; if ({busy, i_done, i_rdata} !== 18'h0) begin errors++; $display("FAIL fetch_c4_idle got %h expected 0", {busy, i_done, i_rdata}); end
  endtask

  task automatic test_zero_wait_store();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    step();
    m_ready = 1'b1; m_rdata = 16'h7777;
    #1;
    checks++; if ({m_en, m_wr} !== 2'b11) begin errors++; $display("FAIL store_en_wr got %b expected 11", {m_en, m_wr}); end
    checks++; if (m_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_wdata got %h expected beef", m_wdata); end
    checks++; if (m_addr !== 16'h0100) begin errors++; $display("FAIL store_addr got %h expected 0100", m_addr); end
    checks++; if ({d_done, i_done} !== 2'b10) begin errors++; $display("FAIL store_done got %b expected 10", {d_done, i_done}); end
    step();
    m_ready = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    #1;
    checks++; if ({busy, m_en, d_done} !== 3'b000) begin errors++; $display("FAIL store_next_idle got %b expected 000", {busy, m_en, d_done}); end
  endtask

  task automatic test_starvation();
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_addr = 16'h0300; d_wr = 1'b0;
    for (int g = 0; g < 10; g++) begin
      step(); // BUSY cycle of grant g
      m_ready = 1'b1; m_rdata = 16'hA000 + 16'(g);
      #1;
      if ((g % 5) == 4) begin
        checks++; if ({i_done, d_done} !== 2'b10) begin errors++; $display("FAIL starve_grant%0d got %b expected 10 (I)", g, {i_done, d_done}); end
        checks++; if (m_addr !== 16'h0200) begin errors++; $display("FAIL starve_addr%0d got %h expected 0200", g, m_addr); end
      end else begin
        checks++; if ({i_done, d_done} !== 2'b01) begin errors++; $display("FAIL starve_grant%0d got %b expected 01 (D)", g, {i_done, d_done}); end
        checks++; if (d_rdata !== 16'hA000 + 16'(g)) begin errors++; $display("FAIL starve_rdata%0d got %h expected %h", g, d_rdata, 16'hA000 + 16'(g)); end
      end
      step(); // IDLE, re-arbitration
      m_ready = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_end_busy got %b expected 0", busy); end
  endtask

  // Runs a load that waits until BUSY cycle 14 (the last allowed one).
  task automatic test_tmo_ready_wins();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    for (int k = 0; k < 14; k++) begin
      step();
      #1;
      checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL tmo_rw_early_done k=%0d got %b expected 0", k, d_done); end
    end
    step(); // k = 14
    m_ready = 1'b1; m_rdata = 16'h4242;
    #1;
    checks++; if ({d_done, d_rdata} !== {1'b1, 16'h4242}) begin errors++; $display("FAIL tmo_rw_done got %h expected 14242", {d_done, d_rdata}); end
    step();
    m_ready = 1'b0; d_req = 1'b0;
    #1;
    checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL tmo_rw_err got %b expected 00", {err, busy}); end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
    m_rdata = 16'hAAAA;
    for (int k = 0; k < 14; k++) begin
      step();
      #1;
      if (k == 0) begin
        checks++; if (m_en !== 1'b1) begin errors++; $display("FAIL tmo_m_en got %b expected 1", m_en); end
      end
      checks++; if ({d_done, err} !== 2'b00) begin errors++; $display("FAIL tmo_early k=%0d got %b expected 00", k, {d_done, err}); end
    end
    step(); // k = 14, 15th cycle from m_en inclusive
    #1;
    checks++; if ({d_done, d_rdata} !== 17'h10000) begin errors++; $display("FAIL tmo_abort got %h expected 10000", {d_done, d_rdata}); end
    step();
    d_req = 1'b0;
    #1;
    checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL tmo_err_set got %b expected 10", {err, busy}); end
    i_req = 1'b1; i_addr = 16'h0550;
    step();
    m_ready = 1'b1; m_rdata = 16'h5555;
    #1;
    checks++; if ({i_done, i_rdata} !== {1'b1, 16'h5555}) begin errors++; $display("FAIL tmo_later_fetch got %h expected 15555", {i_done, i_rdata}); end
    step();
    m_ready = 1'b0; i_req = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b expected 1", err); end
  endtask

  task automatic test_withdrawn();
    i_req = 1'b1; i_addr = 16'h0600;
    step(); // cycle 1, m_en
    step(); // cycle 2
    i_req = 1'b0;
    #1;
    checks++; if ({m_en, busy} !== 2'b01) begin errors++; $display("FAIL wd_c2 got %b expected 01", {m_en, busy}); end
    step(); // cycle 3
    #1;
    checks++; if ({m_en, i_done} !== 2'b00) begin errors++; $display("FAIL wd_c3 got %b expected 00", {m_en, i_done}); end
    step(); // cycle 4
    m_ready = 1'b1; m_rdata = 16'h0F0F;
    #1;
    checks++; if ({i_done, i_rdata} !== {1'b1, 16'h0F0F}) begin errors++; $display("FAIL wd_done got %h expected 10f0f", {i_done, i_rdata}); end
    step();
    m_ready = 1'b0;
    #1;
    checks++; if ({m_en, busy} !== 2'b00) begin errors++; $display("FAIL wd_after got %b expected 00", {m_en, busy}); end
    step();
    #1;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL wd_no_second_m_en got %b expected 0", m_en); end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
    step(); // BUSY_D, m_en
    step(); // second BUSY_D cycle
    rst = 1'b1; m_ready = 1'b1; m_rdata = 16'h1111;
    #1;
    checks++; if ({d_done, d_rdata} !== 17'h0) begin errors++; $display("FAIL rstmid_done got %h expected 0", {d_done, d_rdata}); end
    step();
    rst = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    #1;
    checks++; if ({busy, err, m_en, d_done} !== 4'b0000) begin errors++; $display("FAIL rstmid_after got %b expected 0000", {busy, err, m_en, d_done}); end
    step();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_zero_wait_store();
    test_starvation();
    test_tmo_ready_wins();
    test_timeout();
    test_withdrawn();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
